// File: rtl/dmem_pkg.sv
`default_nettype none
// ============================================================================
// Module      : dmem_pkg
// Description : Shared size encodings, FSM states and byte-mask constants for
//               the MEM-stage data-memory access unit.
// Revision    : 1.0 - initial release
// ============================================================================
package dmem_pkg;

    // Access size encoding as produced by decode (lwhb/swhb)
    localparam logic [1:0] SZ_NONE = 2'b00;
    localparam logic [1:0] SZ_B    = 2'b01;
    localparam logic [1:0] SZ_H    = 2'b10;
    localparam logic [1:0] SZ_W    = 2'b11;

    localparam logic [3:0] c_mask_byte = 4'b0001;
    localparam logic [3:0] c_mask_half = 4'b0011;
    localparam logic [3:0] c_mask_word = 4'b1111;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_REQ   = 3'd1,
        ST_RESP  = 3'd2,
        ST_REQ2  = 3'd3,
        ST_RESP2 = 3'd4,
        ST_DONE  = 3'd5
    } state_t;

    function automatic logic [3:0] base_mask(input logic [1:0] size);
        case (size)
            SZ_B:    return c_mask_byte;
            SZ_H:    return c_mask_half;
            SZ_W:    return c_mask_word;
            default: return 4'b0000;
        endcase
    endfunction

endpackage
`default_nettype wire

// File: rtl/dmem_lane_align.sv
`default_nettype none
// ============================================================================
// Module      : dmem_lane_align
// Description : Combinational byte-lane steering. Produces strobes and shifted
//               store data for both words of a (possibly split) access, and
//               extracts/extends load data from a low/high word pair.
// Revision    : 1.0 - initial release
// ============================================================================
module dmem_lane_align
    import dmem_pkg::*;
(
    input  logic [1:0]  i_size,
    input  logic [1:0]  i_off,
    input  logic        i_unsigned,
    input  logic [31:0] i_wdata,
    input  logic [31:0] i_rdata_lo,
    input  logic [31:0] i_rdata_hi,
    output logic [3:0]  o_wstrb_lo,
    output logic [3:0]  o_wstrb_hi,
    output logic [31:0] o_wdata_lo,
    output logic [31:0] o_wdata_hi,
    output logic [31:0] o_rdata
);

    logic [4:0]  w_shamt;
    logic [7:0]  w_mask8;
    logic [63:0] w_wdata64;
    logic [31:0] w_rdata_sh;

    // The access is viewed as an 8-byte window spanning the word and its
    // successor; the upper half only ever carries data for split accesses.
    assign w_shamt    = {i_off, 3'b000};
    assign w_mask8    = {4'b0000, base_mask(i_size)} << i_off;
    assign w_wdata64  = {32'h0, i_wdata} << w_shamt;
    assign w_rdata_sh = 32'({i_rdata_hi, i_rdata_lo} >> w_shamt);

    assign o_wstrb_lo = w_mask8[3:0];
    assign o_wstrb_hi = w_mask8[7:4];
    assign o_wdata_lo = w_wdata64[31:0];
    assign o_wdata_hi = w_wdata64[63:32];

    always_comb begin
        o_rdata = 32'h0;
        case (i_size)
            SZ_B: o_rdata = i_unsigned ? {24'h0, w_rdata_sh[7:0]}
                                       : {{24{w_rdata_sh[7]}}, w_rdata_sh[7:0]};
            SZ_H: o_rdata = i_unsigned ? {16'h0, w_rdata_sh[15:0]}
                                       : {{16{w_rdata_sh[15]}}, w_rdata_sh[15:0]};
            SZ_W: o_rdata = w_rdata_sh;
            default: o_rdata = 32'h0;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/dmem_access_unit.sv
`default_nettype none
// ============================================================================
// Module      : dmem_access_unit
// Description : MEM-stage load/store responder driving a valid/ready word bus.
//               Define MISALIGN_SPLIT_EN to split word-crossing accesses into
//               two bus transactions instead of rejecting them.
// Revision    : 1.0 - initial release
// ============================================================================
module dmem_access_unit
    import dmem_pkg::*;
#(
    parameter int AW = 32,
    parameter int DW = 32
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          req_valid,
    input  logic          req_we,
    input  logic [1:0]    req_size,
    input  logic          req_unsigned,
    input  logic [AW-1:0] req_addr,
    input  logic [DW-1:0] req_wdata,
    output logic          stall,
    output logic          rsp_valid,
    output logic [DW-1:0] rsp_rdata,
    output logic          misaligned,
    output logic          bus_valid,
    output logic          bus_we,
    output logic [AW-1:0] bus_addr,
    output logic [3:0]    bus_wstrb,
    output logic [DW-1:0] bus_wdata,
    input  logic          bus_ready,
    input  logic          bus_rvalid,
    input  logic [DW-1:0] bus_rdata
);

    state_t        r_state;
    state_t        w_next;

    logic          r_we;
    logic [1:0]    r_size;
    logic          r_unsigned;
    logic [AW-1:0] r_addr;
    logic [DW-1:0] r_wdata;
    logic [DW-1:0] r_rdata;
    logic          r_misaligned;
    logic [DW-1:0] r_lo_word;

    logic          w_reject;
    logic          w_cross;
    logic [AW-1:0] w_word_addr;
    logic [3:0]    w_wstrb_lo;
    logic [3:0]    w_wstrb_hi;
    logic [DW-1:0] w_wdata_lo;
    logic [DW-1:0] w_wdata_hi;
    logic [DW-1:0] w_rdata_lo;
    logic [DW-1:0] w_load_data;

`ifdef MISALIGN_SPLIT_EN
    // Nothing is rejected; only accesses spilling past the word need a
    // second transaction.
    assign w_reject = 1'b0;
    assign w_cross  = ((r_size == SZ_H) && (r_addr[1:0] == 2'd3)) ||
                      ((r_size == SZ_W) && (r_addr[1:0] != 2'd0));
`else
    assign w_reject = ((req_size == SZ_H) && req_addr[0]) ||
                      ((req_size == SZ_W) && (req_addr[1:0] != 2'd0));
    assign w_cross  = 1'b0;
`endif

    assign w_word_addr = {r_addr[AW-1:2], 2'b00};
    // In the second phase the first word comes from the capture register and
    // the live bus word is the upper half of the merge window.
    assign w_rdata_lo  = (r_state == ST_RESP2) ? r_lo_word : bus_rdata;

    dmem_lane_align u_lane_align (
        .i_size     (r_size),
        .i_off      (r_addr[1:0]),
        .i_unsigned (r_unsigned),
        .i_wdata    (r_wdata),
        .i_rdata_lo (w_rdata_lo),
        .i_rdata_hi (bus_rdata),
        .o_wstrb_lo (w_wstrb_lo),
        .o_wstrb_hi (w_wstrb_hi),
        .o_wdata_lo (w_wdata_lo),
        .o_wdata_hi (w_wdata_hi),
        .o_rdata    (w_load_data)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next    = r_state;
        bus_valid = 1'b0;
        bus_we    = 1'b0;
        bus_addr  = '0;
        bus_wstrb = 4'b0000;
        bus_wdata = '0;
        rsp_valid = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (req_valid) begin
                    if ((req_size == SZ_NONE) || w_reject) begin
                        w_next = ST_DONE;
                    end else begin
                        w_next = ST_REQ;
                    end
                end
            end
            ST_REQ: begin
                bus_valid = 1'b1;
                bus_we    = r_we;
                bus_addr  = w_word_addr;
                bus_wstrb = w_wstrb_lo;
                bus_wdata = w_wdata_lo;
                if (bus_ready) begin
                    if (!r_we) begin
                        w_next = ST_RESP;
                    end else if (w_cross) begin
                        w_next = ST_REQ2;
                    end else begin
                        w_next = ST_DONE;
                    end
                end
            end
            ST_RESP: begin
                if (bus_rvalid) begin
                    w_next = w_cross ? ST_REQ2 : ST_DONE;
                end
            end
            ST_REQ2: begin
                bus_valid = 1'b1;
                bus_we    = r_we;
                bus_addr  = w_word_addr + AW'(4);
                bus_wstrb = w_wstrb_hi;
                bus_wdata = w_wdata_hi;
                if (bus_ready) begin
                    w_next = r_we ? ST_DONE : ST_RESP2;
                end
            end
            ST_RESP2: begin
                if (bus_rvalid) begin
                    w_next = ST_DONE;
                end
            end
            ST_DONE: begin
                rsp_valid = 1'b1;
                w_next    = ST_IDLE;
            end
            default: w_next = ST_IDLE;
        endcase
    end

    assign stall      = req_valid && (r_state != ST_DONE);
    assign rsp_rdata  = r_rdata;
    assign misaligned = r_misaligned;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_we         <= 1'b0;
            r_size       <= SZ_NONE;
            r_unsigned   <= 1'b0;
            r_addr       <= '0;
            r_wdata      <= '0;
            r_rdata      <= '0;
            r_misaligned <= 1'b0;
            r_lo_word    <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (req_valid) begin
                        r_we         <= req_we;
                        r_size       <= req_size;
                        r_unsigned   <= req_unsigned;
                        r_addr       <= req_addr;
                        r_wdata      <= req_wdata;
                        r_rdata      <= '0;
                        r_misaligned <= w_reject;
                    end
                end
                ST_RESP: begin
                    if (bus_rvalid) begin
                        if (w_cross) begin
                            r_lo_word <= bus_rdata;
                        end else begin
                            r_rdata <= w_load_data;
                        end
                    end
                end
                ST_RESP2: begin
                    if (bus_rvalid) begin
                        r_rdata <= w_load_data;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_dmem_access_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_dmem_access_unit
// Description : Directed plus randomized bench with a byte-addressed reference
//               memory model and a bus slave with programmable wait states.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_dmem_access_unit;

`ifdef MISALIGN_SPLIT_EN
    localparam bit SPLIT = 1'b1;
`else
    localparam bit SPLIT = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset;
    logic        req_valid, req_we, req_unsigned;
    logic [1:0]  req_size;
    logic [31:0] req_addr, req_wdata;
    logic        stall, rsp_valid, misaligned;
    logic [31:0] rsp_rdata;
    logic        bus_valid, bus_we, bus_ready, bus_rvalid;
    logic [31:0] bus_addr, bus_wdata, bus_rdata;
    logic [3:0]  bus_wstrb;

    always #5 clk = ~clk;

    dmem_access_unit dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_we(req_we), .req_size(req_size),
        .req_unsigned(req_unsigned), .req_addr(req_addr), .req_wdata(req_wdata),
        .stall(stall), .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata),
        .misaligned(misaligned), .bus_valid(bus_valid), .bus_we(bus_we),
        .bus_addr(bus_addr), .bus_wstrb(bus_wstrb), .bus_wdata(bus_wdata),
        .bus_ready(bus_ready), .bus_rvalid(bus_rvalid), .bus_rdata(bus_rdata)
    );

    typedef struct packed {
        logic [31:0] addr;
        logic        we;
        logic [3:0]  strb;
        logic [31:0] wdata;
    } txn_t;

    int          checks = 0;
    int          errors = 0;
    logic [7:0]  ref_mem [int];
    logic [7:0]  slv_mem [int];
    txn_t        got_q [$];
    int          rsp_cyc;
    logic [31:0] last_rdata;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] init_byte(input logic [31:0] a);
        return 8'(a * 37 + 11);
    endfunction

    function automatic logic [7:0] ref_byte(input logic [31:0] a);
        return ref_mem.exists(int'(a)) ? ref_mem[int'(a)] : init_byte(a);
    endfunction

    function automatic logic [31:0] slv_word(input logic [31:0] wa);
        logic [31:0] w;
        for (int l = 0; l < 4; l++)
            w[8*l +: 8] = slv_mem.exists(int'(wa + l)) ? slv_mem[int'(wa + l)] : init_byte(wa + l);
        return w;
    endfunction

    function automatic logic [31:0] lane_mask(input logic [3:0] s);
        return {{8{s[3]}}, {8{s[2]}}, {8{s[1]}}, {8{s[0]}}};
    endfunction

    task automatic preload_word(input logic [31:0] wa, input logic [31:0] v);
        for (int l = 0; l < 4; l++) begin
            ref_mem[int'(wa + l)] = v[8*l +: 8];
            slv_mem[int'(wa + l)] = v[8*l +: 8];
        end
    endtask

    // One pipeline request: model expectation, act as bus slave, check result.
    task automatic do_access(input logic we, input logic [1:0] size, input logic uns,
                             input logic [31:0] addr, input logic [31:0] wdata,
                             input int rdly, input int vdly, input string tag);
        int          n, ne, wait_c, rv_pend;
        logic        reject, in_req, stable, stall_ok, done;
        logic [31:0] exp_rd, ba, w0, rv_addr;
        txn_t        et [2];
        txn_t        snap, cur;

        n      = (size == 2'b01) ? 1 : (size == 2'b10) ? 2 : (size == 2'b11) ? 4 : 0;
        reject = !SPLIT && (((n == 2) && addr[0]) || ((n == 4) && (addr[1:0] != 2'b00)));
        w0     = {addr[31:2], 2'b00};
        et[0]  = '{addr: w0,     we: we, strb: 4'b0, wdata: 32'h0};
        et[1]  = '{addr: w0 + 4, we: we, strb: 4'b0, wdata: 32'h0};
        exp_rd = 32'h0;
        ne     = 0;
        if ((n > 0) && !reject) begin
            ne = 1;
            for (int i = 0; i < n; i++) begin
                ba = addr + i;
                if ({ba[31:2], 2'b00} != w0) begin
                    ne = 2;
                    et[1].strb[ba[1:0]] = 1'b1;
                    et[1].wdata[8*ba[1:0] +: 8] = wdata[8*i +: 8];
                end else begin
                    et[0].strb[ba[1:0]] = 1'b1;
                    et[0].wdata[8*ba[1:0] +: 8] = wdata[8*i +: 8];
                end
                exp_rd[8*i +: 8] = ref_byte(ba);
            end
            if (n == 1) exp_rd = uns ? {24'h0, exp_rd[7:0]}  : {{24{exp_rd[7]}}, exp_rd[7:0]};
            if (n == 2) exp_rd = uns ? {16'h0, exp_rd[15:0]} : {{16{exp_rd[15]}}, exp_rd[15:0]};
        end

        got_q.delete();
        in_req = 0; stable = 1; stall_ok = 1; done = 0; wait_c = 0; rv_pend = 0;
        rv_addr = 0; snap = '0; rsp_cyc = -1;
        @(negedge clk);
        req_valid = 1; req_we = we; req_size = size; req_unsigned = uns;
        req_addr = addr; req_wdata = wdata; bus_ready = 0; bus_rvalid = 0;
        for (int cyc = 0; cyc < 200; cyc++) begin
            #1;
            if (rsp_valid) begin
                done = 1; rsp_cyc = cyc;
                break;
            end
            if (!stall) stall_ok = 0;
            bus_ready = 0; bus_rvalid = 0; bus_rdata = $urandom;
            if (rv_pend > 0) begin
                rv_pend--;
                if (rv_pend == 0) begin
                    bus_rvalid = 1;
                    bus_rdata  = slv_word(rv_addr);
                end
            end
            if (bus_valid) begin
                cur = '{addr: bus_addr, we: bus_we, strb: bus_wstrb, wdata: bus_wdata};
                if (!in_req) begin
                    in_req = 1; wait_c = 0; snap = cur;
                end else if (cur !== snap) begin
                    stable = 0;
                end
                if (wait_c >= rdly) begin
                    bus_ready = 1; in_req = 0;
                    got_q.push_back(snap);
                    if (snap.we) begin
                        for (int l = 0; l < 4; l++)
                            if (snap.strb[l]) slv_mem[int'(snap.addr + l)] = snap.wdata[8*l +: 8];
                    end else begin
                        rv_pend = vdly; rv_addr = snap.addr;
                    end
                end else begin
                    wait_c++;
                end
            end
            @(negedge clk);
        end

        chk({tag, " completed"}, 32'(done), 32'd1);
        if (done) begin
            last_rdata = rsp_rdata;
            chk({tag, " misaligned"}, 32'(misaligned), 32'(reject));
            chk({tag, " stall_in_done"}, 32'(stall), 32'd0);
            chk({tag, " stall_while_busy"}, 32'(stall_ok), 32'd1);
            chk({tag, " bus_stable"}, 32'(stable), 32'd1);
            if (!we && !reject) chk({tag, " rdata"}, rsp_rdata, exp_rd);
            chk({tag, " txn_count"}, 32'(got_q.size()), 32'(ne));
            for (int k = 0; k < ne && k < got_q.size(); k++) begin
                chk({tag, " txn_addr"}, got_q[k].addr, et[k].addr);
                chk({tag, " txn_we"}, 32'(got_q[k].we), 32'(et[k].we));
                chk({tag, " txn_strb"}, 32'(got_q[k].strb), 32'(et[k].strb));
                if (we) chk({tag, " txn_wdata"}, got_q[k].wdata & lane_mask(et[k].strb), et[k].wdata);
            end
        end
        if (we && !reject)
            for (int i = 0; i < n; i++) ref_mem[int'(addr + i)] = wdata[8*i +: 8];

        // Following cycle is IDLE; a stray rvalid there must be ignored.
        req_valid = 0; bus_ready = 0; bus_rvalid = 1'($urandom);
        @(negedge clk); #1;
        chk({tag, " idle_after_done"}, {30'h0, rsp_valid, bus_valid}, 32'h0);
        bus_rvalid = 0;
    endtask

    // Reset asserted mid-transaction; bus_valid must drop without a clock edge.
    task automatic reset_mid(input bit in_resp, input string tag);
        int seen;
        @(negedge clk);
        req_valid = 1; req_we = 0; req_size = 2'b11; req_unsigned = 0;
        req_addr = 32'h200; req_wdata = 0; bus_ready = in_resp; bus_rvalid = 0;
        @(negedge clk); #1;
        chk({tag, " in_req"}, 32'(bus_valid), 32'd1);
        if (in_resp) begin
            @(negedge clk); #1;
        end
        bus_ready = 0;
        #1 reset = 1;
        #1;
        chk({tag, " bus_valid_drop"}, 32'(bus_valid), 32'd0);
        chk({tag, " rsp_after_reset"}, {31'h0, rsp_valid} | rsp_rdata, 32'h0);
        req_valid = 0;
        @(negedge clk); #1;
        reset = 0;
        seen = 0;
        for (int c = 0; c < 4; c++) begin
            bus_rvalid = 1; bus_rdata = 32'hA5A5_5A5A;
            @(negedge clk); #1;
            if (rsp_valid || bus_valid || stall) seen++;
        end
        bus_rvalid = 0;
        chk({tag, " rvalid_ignored"}, 32'(seen), 32'd0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1; req_valid = 0; req_we = 0; req_size = 0; req_unsigned = 0;
        req_addr = 0; req_wdata = 0; bus_ready = 0; bus_rvalid = 0; bus_rdata = 0;
        repeat (2) @(negedge clk);
        #1;
        chk("reset_ctrl", {28'h0, stall, rsp_valid, misaligned, bus_valid}, 32'h0);
        chk("reset_bus", {31'h0, bus_we} | bus_addr | {28'h0, bus_wstrb} | bus_wdata, 32'h0);
        chk("reset_rdata", rsp_rdata, 32'h0);
        reset = 0;

        do_access(1, 2'b11, 0, 32'h100, 32'hDEADBEEF, 0, 1, "sw");
        chk("sw_latency", 32'(rsp_cyc), 32'd2);

        preload_word(32'h100, 32'h8000_0000);
        do_access(0, 2'b01, 0, 32'h103, 32'h0, 0, 1, "lb");
        chk("lb_value", last_rdata, 32'hFFFF_FF80);
        do_access(0, 2'b01, 1, 32'h103, 32'h0, 0, 1, "lbu");
        chk("lbu_value", last_rdata, 32'h0000_0080);

        do_access(1, 2'b10, 0, 32'h22, 32'h0000_ABCD, 3, 1, "sh");
        chk("sh_wdata_full", (got_q.size() > 0) ? got_q[0].wdata : 32'hX, 32'hABCD_0000);

        do_access(0, 2'b00, 0, 32'h40, 32'h0, 0, 1, "size_none");

        preload_word(32'h100, 32'h4433_2211);
        preload_word(32'h104, 32'h8877_6655);
        do_access(0, 2'b11, 0, 32'h102, 32'h0, 0, 1, "lw_misal");
        if (SPLIT) begin
            chk("lw_split_value", last_rdata, 32'h6655_4433);
        end else begin
            chk("lw_reject_latency", 32'(rsp_cyc), 32'd1);
        end

        reset_mid(1'b0, "rst_req");
        reset_mid(1'b1, "rst_resp");
        preload_word(32'h200, 32'h1234_5678);
        do_access(0, 2'b11, 0, 32'h200, 32'h0, 0, 1, "lw_after_reset");
        chk("lw_after_reset_value", last_rdata, 32'h1234_5678);

        for (int t = 0; t < 200; t++) begin
            do_access(1'($urandom), 2'($urandom), 1'($urandom),
                      32'h300 + $urandom_range(0, 63), $urandom,
                      $urandom_range(0, 2), $urandom_range(1, 3), "rand");
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
